// File: rtl/branch_unit_ras_if.sv
// Interface between a branch unit and its issue stage: op/flag inputs, PC and RAS status outputs.
interface branch_unit_ras_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic            stall;
  logic            op_valid;
  logic [3:0]      branch_op;
  logic [XLEN-1:0] label;
  logic            neg;
  logic            carry;
  logic            zero;
  logic            clear_flags;

  logic [XLEN-1:0] pc;
  logic            taken;
  logic [XLEN-1:0] ras_top;
  logic [CntW-1:0] ras_count;
  logic            ras_overflow;
  logic            ras_underflow;

  modport master (
    output stall, op_valid, branch_op, label, neg, carry, zero, clear_flags,
    input  pc, taken, ras_top, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, op_valid, branch_op, label, neg, carry, zero, clear_flags,
    output pc, taken, ras_top, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/branch_unit_ras.sv
// PC register and branch resolution with a circular return-address stack,
// stall support and sticky RAS overflow/underflow flags.
module branch_unit_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC   = 32'h0000_0100
) (
  input logic              clk,
  input logic              reset,
  branch_unit_ras_if.slave bus
);
  localparam int unsigned     PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned     CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(RAS_DEPTH);

  typedef enum logic [3:0] {
    OpSeq  = 4'd0,
    OpB    = 4'd1,
    OpBl   = 4'd2,
    OpBcy  = 4'd3,
    OpBncy = 4'd4,
    OpBr   = 4'd5,
    OpBltz = 4'd6,
    OpBz   = 4'd7,
    OpBnz  = 4'd8
  } op_e;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [XLEN-1:0] entries_q [RAS_DEPTH];

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] label_al;
  logic [XLEN-1:0] top_val;
  logic [PtrW-1:0] push_idx;
  logic            empty, full;
  logic            push, pop;
  logic            cond;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign label_al = bus.label & ~XLEN'(3);
  assign empty    = (count_q == '0);
  assign full     = (count_q == Full);
  assign top_val  = empty ? '0 : entries_q[top_q];
  assign push_idx = top_q + PtrW'(1);

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    cond    = 1'b0;
    if (!bus.stall) begin
      pc_d = pc_plus4;
      if (bus.op_valid) begin
        case (op_e'(bus.branch_op))
          OpB:    cond = 1'b1;
          OpBl: begin
            cond = 1'b1;
            push = 1'b1;
          end
          OpBcy:  cond = bus.carry;
          OpBncy: cond = !bus.carry;
          OpBltz: cond = bus.neg && !bus.zero;
          OpBz:   cond = bus.zero;
          OpBnz:  cond = !bus.zero;
          OpBr: begin
            pop     = 1'b1;
            taken_d = 1'b1;
            pc_d    = empty ? TRAP_PC : top_val;
          end
          default: ;
        endcase
        if (cond) begin
          pc_d    = label_al;
          taken_d = 1'b1;
        end
      end
    end
  end

  // A push onto a full stack overwrites the oldest entry, so count saturates.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (push) begin
      top_d   = push_idx;
      count_d = full ? count_q : count_q + CntW'(1);
    end else if (pop && !empty) begin
      top_d   = top_q - PtrW'(1);
      count_d = count_q - CntW'(1);
    end
    ovf_d = (ovf_q && !bus.clear_flags) || (push && full);
    unf_d = (unf_q && !bus.clear_flags) || (pop && empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push) begin
        entries_q[push_idx] <= pc_plus4;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.taken         = taken_q;
  assign bus.ras_top       = top_val;
  assign bus.ras_count     = count_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed bench for branch_unit_ras: queue-based reference model checked every cycle,
// plus literal expectations taken from hand-worked branch sequences.
module tb_branch_unit_ras;
  localparam int unsigned   XLEN  = 32;
  localparam int unsigned   DEPTH = 4;
  localparam logic [31:0]   RST_PC  = 32'h0000_0000;
  localparam logic [31:0]   TRP_PC  = 32'h0000_0100;

  localparam logic [3:0] OpSeq = 4'd0, OpB = 4'd1, OpBl = 4'd2, OpBcy = 4'd3, OpBncy = 4'd4,
                         OpBr = 4'd5, OpBltz = 4'd6, OpBz = 4'd7, OpBnz = 4'd8;

  logic clk;
  logic reset;

  branch_unit_ras_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  branch_unit_ras #(
    .XLEN     (XLEN),
    .RAS_DEPTH(DEPTH),
    .RESET_PC (RST_PC),
    .TRAP_PC  (TRP_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the RAS is a queue of return addresses, newest at the back.
  logic [31:0] m_pc;
  logic        m_taken;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  task automatic model_step();
    logic [31:0] nxt;
    logic [31:0] lbl;
    logic        tk;
    if (!reset) begin
      m_pc = RST_PC; m_taken = 1'b0; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (bus.clear_flags) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (bus.stall) begin
      m_taken = 1'b0;
      return;
    end
    nxt = m_pc + 32'd4;
    lbl = bus.label & 32'hFFFF_FFFC;
    tk  = 1'b0;
    if (bus.op_valid) begin
      case (bus.branch_op)
        OpB:    tk = 1'b1;
        OpBl: begin
          tk = 1'b1;
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(m_pc + 32'd4);
        end
        OpBcy:  tk = bus.carry;
        OpBncy: tk = !bus.carry;
        OpBltz: tk = bus.neg && !bus.zero;
        OpBz:   tk = bus.zero;
        OpBnz:  tk = !bus.zero;
        default: ;
      endcase
      if (tk) nxt = lbl;
      if (bus.branch_op == OpBr) begin
        tk = 1'b1;
        if (m_ras.size() == 0) begin
          nxt   = TRP_PC;
          m_unf = 1'b1;
        end else begin
          nxt = m_ras.pop_back();
        end
      end
    end
    m_pc    = nxt;
    m_taken = tk;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      model_step();
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_top;
    exp_top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1];
    chk("model_pc", bus.pc, m_pc);
    chk("model_taken", 32'(bus.taken), 32'(m_taken));
    chk("model_ras_top", bus.ras_top, exp_top);
    chk("model_ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    chk("model_ovf", 32'(bus.ras_overflow), 32'(m_ovf));
    chk("model_unf", 32'(bus.ras_underflow), 32'(m_unf));
  end

  task automatic drive(input logic s, input logic v, input logic [3:0] op, input logic [31:0] lbl,
                       input logic n, input logic c, input logic z, input logic clr);
    bus.stall = s; bus.op_valid = v; bus.branch_op = op; bus.label = lbl;
    bus.neg = n; bus.carry = c; bus.zero = z; bus.clear_flags = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, OpSeq, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] lbl);
    drive(1'b0, 1'b1, op, lbl, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cond_case(input string name, input logic [3:0] op, input logic n, input logic c,
                           input logic z, input logic [31:0] exp_pc, input logic exp_tk);
    do_op(OpB, 32'h20);
    drive(1'b0, 1'b1, op, 32'h80, n, c, z, 1'b0);
    chk(name, bus.pc, exp_pc);
    chk({name, "_taken"}, 32'(bus.taken), 32'(exp_tk));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.stall = 1'b0; bus.op_valid = 1'b0; bus.branch_op = 4'd0; bus.label = 32'h0;
    bus.neg = 1'b0; bus.carry = 1'b0; bus.zero = 1'b0; bus.clear_flags = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_taken", 32'(bus.taken), 32'h0);
    chk("rst_count", 32'(bus.ras_count), 32'h0);
    reset = 1'b1;

    // Sequential fetch
    idle(); chk("seq_pc4", bus.pc, 32'h4);
    idle(); chk("seq_pc8", bus.pc, 32'h8);
    idle(); chk("seq_pcc", bus.pc, 32'hC);
    chk("seq_taken", 32'(bus.taken), 32'h0);
    idle(); chk("seq_pc10", bus.pc, 32'h10);

    // bl / br pair
    do_op(OpBl, 32'h200);
    chk("bl_pc", bus.pc, 32'h200);
    chk("bl_taken", 32'(bus.taken), 32'h1);
    chk("bl_top", bus.ras_top, 32'h14);
    do_op(OpBr, 32'h0);
    chk("br_pc", bus.pc, 32'h14);
    chk("br_count", 32'(bus.ras_count), 32'h0);

    // Overflow then drain to underflow
    do_op(OpB, 32'h0);
    do_op(OpBl, 32'h40);
    do_op(OpBl, 32'h80);
    do_op(OpBl, 32'hC0);
    do_op(OpBl, 32'h100);
    chk("ovf_clear_before", 32'(bus.ras_overflow), 32'h0);
    do_op(OpBl, 32'h140);
    chk("ovf_flag", 32'(bus.ras_overflow), 32'h1);
    chk("ovf_count", 32'(bus.ras_count), 32'h4);
    do_op(OpBr, 32'h0); chk("ret1", bus.pc, 32'h104);
    do_op(OpBr, 32'h0); chk("ret2", bus.pc, 32'hC4);
    do_op(OpBr, 32'h0); chk("ret3", bus.pc, 32'h84);
    do_op(OpBr, 32'h0); chk("ret4", bus.pc, 32'h44);
    do_op(OpBr, 32'h0);
    chk("trap_pc", bus.pc, 32'h100);
    chk("trap_taken", 32'(bus.taken), 32'h1);
    chk("unf_flag", 32'(bus.ras_underflow), 32'h1);

    // Conditionals
    cond_case("bcy_c1", OpBcy, 1'b0, 1'b1, 1'b0, 32'h80, 1'b1);
    cond_case("bncy_c1", OpBncy, 1'b0, 1'b1, 1'b0, 32'h24, 1'b0);
    cond_case("bltz_neg", OpBltz, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1);
    cond_case("bltz_zero", OpBltz, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0);
    cond_case("bz_z1", OpBz, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
    cond_case("bnz_z1", OpBnz, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0);
    cond_case("undef_op", 4'hC, 1'b1, 1'b1, 1'b1, 32'h24, 1'b0);

    // Stall holds everything
    drive(1'b1, 1'b1, OpB, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall1_pc", bus.pc, 32'h24);
    chk("stall1_taken", 32'(bus.taken), 32'h0);
    drive(1'b1, 1'b1, OpB, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall2_pc", bus.pc, 32'h24);
    do_op(OpB, 32'h300);
    chk("unstall_pc", bus.pc, 32'h300);
    chk("unstall_taken", 32'(bus.taken), 32'h1);
    do_op(OpB, 32'hFFFF_FFFC);
    idle(); chk("wrap_pc", bus.pc, 32'h0);
    do_op(OpB, 32'h203); chk("label_align", bus.pc, 32'h200);

    // Asynchronous reset in the middle of a stalled cycle
    do_op(OpBl, 32'h400);
    do_op(OpBl, 32'h500);
    chk("pre_rst_count", 32'(bus.ras_count), 32'h2);
    chk("pre_rst_ovf", 32'(bus.ras_overflow), 32'h1);
    chk("pre_rst_unf", 32'(bus.ras_underflow), 32'h1);
    bus.stall = 1'b1; bus.op_valid = 1'b1; bus.branch_op = OpB; bus.label = 32'h700;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc, RST_PC);
    chk("async_rst_count", 32'(bus.ras_count), 32'h0);
    chk("async_rst_top", bus.ras_top, 32'h0);
    chk("async_rst_ovf", 32'(bus.ras_overflow), 32'h0);
    chk("async_rst_unf", 32'(bus.ras_underflow), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Overflow and clear_flags in the same cycle: set wins
    do_op(OpBl, 32'h40);
    do_op(OpBl, 32'h80);
    do_op(OpBl, 32'hC0);
    do_op(OpBl, 32'h100);
    drive(1'b0, 1'b1, OpBl, 32'h140, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("set_wins_ovf", 32'(bus.ras_overflow), 32'h1);
    chk("set_wins_top", bus.ras_top, 32'h104);
    drive(1'b0, 1'b0, OpSeq, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", 32'(bus.ras_overflow), 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
